// File: rtl/mem_access_unit.sv
// mem_access_unit
//
// Pipeline-side initiator for the word-wide data memory. Accepts one load
// or store at a time from the MEM stage and drives the memory port. The
// memory has no byte enables, so halfword and byte stores are done as a
// read-modify-write (RD then WR). Sub-word loads are extracted from the
// read word and sign- or zero-extended. Busy stalls the pipeline while an
// access is in RD or WR.
//
// Optional feature macro: MAU_MISALIGN_CHECK_EN
//   defined   : misaligned LW/SW (Addr[1:0]!=0) and LH/LHU/SH (Addr[0]=1)
//               are rejected at acceptance with Done=Fault=1 and no strobe.
//   undefined : Fault stays 0, low address bits below the access size are
//               ignored and the access proceeds normally.
//
// Ports:
//   Clk           system clock (block is posedge, memory samples negedge)
//   Reset         synchronous active-high reset
//   Req           access request, sampled only in IDLE or DONE
//   Op[2:0]       000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
//   Addr[31:0]    byte address
//   StoreData     store source ([7:0] for SB, [15:0] for SH)
//   Busy          stall, high in RD and WR
//   Done          one-cycle completion pulse
//   LoadData      extended load result, held until the next load completes
//   Fault         misaligned-access flag, pulses with Done
//   MemAddress    word-aligned address to memory
//   MemWriteData  write data to memory
//   MemWrite      memory write strobe
//   MemRead       memory read strobe
//   MemReadData   read data from memory

module mem_access_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic [2:0]  Op,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] LoadData,
  output logic        Fault,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemReadData
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [15:0] store_q;

  logic        accept;
  logic        misalign;
  logic        op_is_load;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_value;
  logic [31:0] merged_word;

  assign accept     = Req && ((state == IDLE) || (state == DONE));
  assign op_is_load = (op_q <= OP_LBU);

  // Alignment check on the incoming request; only meaningful when accepting.
`ifdef MAU_MISALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    case (Op)
      OP_LW, OP_SW:         misalign = (Addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misalign = Addr[0];
      default:              misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Next-state logic. Subword stores read first so the other lanes survive.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (Req) begin
          if (misalign)        next_state = DONE;
          else if (Op == OP_SW) next_state = WR;
          else                 next_state = RD;
        end else begin
          next_state = IDLE;
        end
      end
      RD:      next_state = op_is_load ? DONE : WR;
      WR:      next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Little-endian lane extraction from the word returned by memory.
  always_comb begin
    rd_half = lane_q[1] ? MemReadData[31:16] : MemReadData[15:0];
    rd_byte = MemReadData[7:0];
    case (lane_q)
      2'd0: rd_byte = MemReadData[7:0];
      2'd1: rd_byte = MemReadData[15:8];
      2'd2: rd_byte = MemReadData[23:16];
      2'd3: rd_byte = MemReadData[31:24];
      default: rd_byte = MemReadData[7:0];
    endcase
  end

  // Load result with sign/zero extension.
  always_comb begin
    load_value = MemReadData;
    case (op_q)
      OP_LH:   load_value = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_value = {16'h0000, rd_half};
      OP_LB:   load_value = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_value = {24'h000000, rd_byte};
      default: load_value = MemReadData;
    endcase
  end

  // Read-modify-write merge: only the addressed lane takes the store data.
  always_comb begin
    merged_word = MemReadData;
    if (op_q == OP_SH) begin
      if (lane_q[1]) merged_word[31:16] = store_q;
      else           merged_word[15:0]  = store_q;
    end else if (op_q == OP_SB) begin
      case (lane_q)
        2'd0: merged_word[7:0]   = store_q[7:0];
        2'd1: merged_word[15:8]  = store_q[7:0];
        2'd2: merged_word[23:16] = store_q[7:0];
        2'd3: merged_word[31:24] = store_q[7:0];
        default: merged_word = MemReadData;
      endcase
    end
  end

  // State register plus registered outputs. Strobes are derived from the
  // next state so they are already valid during the RD/WR cycle itself.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      op_q         <= 3'b000;
      lane_q       <= 2'b00;
      store_q      <= 16'h0000;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Fault        <= 1'b0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      LoadData     <= 32'h0;
      MemAddress   <= 32'h0;
      MemWriteData <= 32'h0;
    end else begin
      state    <= next_state;
      Busy     <= (next_state == RD) || (next_state == WR);
      MemRead  <= (next_state == RD);
      MemWrite <= (next_state == WR);
      Done     <= (next_state == DONE);
      Fault    <= accept && misalign;

      if (accept) begin
        op_q       <= Op;
        lane_q     <= Addr[1:0];
        store_q    <= StoreData[15:0];
        MemAddress <= {Addr[31:2], 2'b00};
        if ((Op == OP_SW) && !misalign) MemWriteData <= StoreData;
      end

      if (state == RD) begin
        if (op_is_load) LoadData     <= load_value;
        else            MemWriteData <= merged_word;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a small negedge
// memory model holding 16 words.

module tb_mem_access_unit;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  logic        Clk;
  logic        Reset;
  logic        Req;
  logic [2:0]  Op;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic        Busy;
  logic        Done;
  logic [31:0] LoadData;
  logic        Fault;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] MemReadData;

  logic [31:0] mem [16];
  logic        mem_init;
  int          total_reads;
  int          total_writes;
  int          rw_both;
  int          checks;
  int          errors;
  logic [31:0] last_wdata;
  int          lat;
  int          rd0;
  int          wr0;

  mem_access_unit dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Req          (Req),
    .Op           (Op),
    .Addr         (Addr),
    .StoreData    (StoreData),
    .Busy         (Busy),
    .Done         (Done),
    .LoadData     (LoadData),
    .Fault        (Fault),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .MemReadData  (MemReadData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory model: write and read-address capture on negedge.
  always @(negedge Clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[3] <= 32'h8899AABB;
      mem[4] <= 32'h11223344;
      MemReadData <= 32'h0;
    end else begin
      if (MemWrite) mem[MemAddress[5:2]] <= MemWriteData;
      if (MemRead)  MemReadData <= mem[MemAddress[5:2]];
    end
    if (MemRead)  total_reads  <= total_reads + 1;
    if (MemWrite) total_writes <= total_writes + 1;
    if (MemRead && MemWrite) rw_both <= rw_both + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Present a request and let it be accepted at the next posedge (E0).
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
    rd0 = total_reads;
    wr0 = total_writes;
    Req = 1'b1;
    Op = op;
    Addr = addr;
    StoreData = data;
    @(posedge Clk);
    #1;
    Req = 1'b0;
  endtask

  // Returns posedges from E0 until Done is observed; bounded.
  task automatic waitDone(output int latency);
    int cycles;
    cycles = 0;
    while (!Done && cycles < 8) begin
      if (MemWrite) last_wdata = MemWriteData;
      @(posedge Clk);
      #1;
      cycles++;
    end
    latency = cycles + 1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    total_reads = 0;
    total_writes = 0;
    rw_both = 0;
    last_wdata = 32'h0;
    mem_init = 1'b1;
    Reset = 1'b1;
    Req = 1'b0;
    Op = 3'b000;
    Addr = 32'h0;
    StoreData = 32'h0;
    repeat (2) @(posedge Clk);
    #1;
    mem_init = 1'b0;
    checkOutput("rst_ctrl", {27'h0, Busy, Done, Fault, MemWrite, MemRead}, 32'h0);
    checkOutput("rst_load", LoadData, 32'h0);
    checkOutput("rst_addr", MemAddress, 32'h0);
    checkOutput("rst_wdata", MemWriteData, 32'h0);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Sub-word loads from word 3 = 0x8899AABB
    applyStimulus(OP_LB, 32'h0E, 32'h0);
    checkOutput("lb_busy", {31'h0, Busy}, 32'h1);
    checkOutput("lb_mread", {31'h0, MemRead}, 32'h1);
    checkOutput("lb_maddr", MemAddress, 32'h0C);
    waitDone(lat);
    checkOutput("lb_lat", lat, 2);
    checkOutput("lb_data", LoadData, 32'hFFFFFF99);
    checkOutput("lb_fault", {31'h0, Fault}, 32'h0);
    @(posedge Clk);
    #1;
    checkOutput("done_pulse", {30'h0, Done, Busy}, 32'h0);

    applyStimulus(OP_LBU, 32'h0E, 32'h0);
    waitDone(lat);
    checkOutput("lbu_data", LoadData, 32'h00000099);
    @(posedge Clk);
    #1;
    applyStimulus(OP_LH, 32'h0E, 32'h0);
    waitDone(lat);
    checkOutput("lh_hi_data", LoadData, 32'hFFFF8899);
    @(posedge Clk);
    #1;
    applyStimulus(OP_LHU, 32'h0E, 32'h0);
    waitDone(lat);
    checkOutput("lhu_data", LoadData, 32'h00008899);
    @(posedge Clk);
    #1;
    applyStimulus(OP_LH, 32'h0C, 32'h0);
    waitDone(lat);
    checkOutput("lh_lo_data", LoadData, 32'hFFFFAABB);
    @(posedge Clk);
    #1;

    // Byte store: read-modify-write of lane 1
    applyStimulus(OP_SB, 32'h0D, 32'hFFFFFFCC);
    waitDone(lat);
    checkOutput("sb_lat", lat, 3);
    checkOutput("sb_reads", total_reads - rd0, 1);
    checkOutput("sb_writes", total_writes - wr0, 1);
    checkOutput("sb_wdata", last_wdata, 32'h8899CCBB);
    checkOutput("sb_mem", mem[3], 32'h8899CCBB);
    checkOutput("sb_keep_load", LoadData, 32'hFFFFAABB);
    @(posedge Clk);
    #1;
    applyStimulus(OP_LBU, 32'h0F, 32'h0);
    waitDone(lat);
    checkOutput("lbu_lane3", LoadData, 32'h00000088);
    @(posedge Clk);
    #1;

    // SW followed by LW accepted in the DONE cycle
    applyStimulus(OP_SW, 32'h10, 32'hDEADBEEF);
    checkOutput("sw_mwrite", {30'h0, MemWrite, MemRead}, 32'h2);
    waitDone(lat);
    checkOutput("sw_lat", lat, 2);
    checkOutput("sw_reads", total_reads - rd0, 0);
    applyStimulus(OP_LW, 32'h10, 32'h0);
    checkOutput("b2b_busy", {31'h0, Busy}, 32'h1);
    waitDone(lat);
    checkOutput("b2b_lat", lat, 2);
    checkOutput("b2b_data", LoadData, 32'hDEADBEEF);
    @(posedge Clk);
    #1;

    // Reset during the RD phase of a halfword store
    applyStimulus(OP_SH, 32'h0C, 32'h00001234);
    checkOutput("sh_in_rd", {30'h0, MemRead, Busy}, 32'h3);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    checkOutput("mid_rst_ctrl", {27'h0, Busy, Done, Fault, MemWrite, MemRead}, 32'h0);
    checkOutput("mid_rst_load", LoadData, 32'h0);
    checkOutput("mid_rst_addr", MemAddress, 32'h0);
    checkOutput("mid_rst_wdata", MemWriteData, 32'h0);
    repeat (4) @(posedge Clk);
    #1;
    checkOutput("mid_rst_nowrite", total_writes - wr0, 0);
    checkOutput("mid_rst_mem", mem[3], 32'h8899CCBB);

    applyStimulus(OP_LW, 32'h0C, 32'h0);
    waitDone(lat);
    checkOutput("lw_readback", LoadData, 32'h8899CCBB);
    @(posedge Clk);
    #1;

    // Word load at a misaligned address
    applyStimulus(OP_LW, 32'h12, 32'h0);
    waitDone(lat);
`ifdef MAU_MISALIGN_CHECK_EN
    checkOutput("mis_lat", lat, 1);
    checkOutput("mis_fault", {31'h0, Fault}, 32'h1);
    checkOutput("mis_strobes", (total_reads - rd0) + (total_writes - wr0), 0);
    checkOutput("mis_load", LoadData, 32'h8899CCBB);
`else
    checkOutput("mis_lat", lat, 2);
    checkOutput("mis_fault", {31'h0, Fault}, 32'h0);
    checkOutput("mis_load", LoadData, 32'hDEADBEEF);
`endif
    @(posedge Clk);
    #1;

    checkOutput("rw_exclusive", rw_both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Pipeline-side initiator for the word-wide data memory: accepts one load or store request at a time from the MEM stage and drives the memory's Address/WriteData/MemWrite/MemRead port. Sub-word stores are performed as read-modify-write, because the data memory has no byte enables. Sub-word loads are extracted and sign- or zero-extended. The block stalls the pipeline via Busy until the access completes.

## Interface
- No parameters.
- Clk  in  1  system clock. Memory samples on negedge Clk; this block is posedge.
- Reset  in  1  synchronous, active-high reset.
- Req  in  1  access request. Sampled only in IDLE or DONE.
- Op  in  3  access type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- Addr  in  32  byte address.
- StoreData  in  32  store source. Byte stores use [7:0]; halfword stores use [15:0].
- Busy  out  1  stall to pipeline, high in RD and WR.
- Done  out  1  one-cycle completion pulse.
- LoadData  out  32  extended load result. Held until the next load completes.
- Fault  out  1  misaligned-access flag, pulses with Done.
- MemAddress  out  32  to memory Address, always {Addr[31:2],2'b00}.
- MemWriteData  out  32  to memory WriteData.
- MemWrite  out  1  to memory MemWrite.
- MemRead  out  1  to memory MemRead.
- MemReadData  in  32  from memory ReadData.

## Operation
- FSM states: IDLE, RD, WR, DONE. All outputs are registered.
- Request latch: when Req=1 in IDLE or DONE, latch Op, Addr and StoreData.
  - Loads and SH/SB go to RD.
  - SW goes to WR.
  - If Req=0, go to or stay in IDLE.
- DONE always leaves after one cycle, either to IDLE or to a newly accepted request.
- RD state:
  - MemRead=1, MemWrite=0.
  - At the closing posedge, MemReadData is captured.
  - Loads: write the extracted value to LoadData, then go to DONE.
  - SH/SB: merge into the captured word, then go to WR.
- WR state:
  - MemWrite=1, MemRead=0.
  - MemWriteData = StoreData (SW) or the merged word (SH/SB).
  - Then go to DONE.
- Lane selection (little-endian):
  - Byte lane b = Addr[1:0] occupies bits [8b+7:8b].
  - Halfword: Addr[1]=0 selects [15:0], Addr[1]=1 selects [31:16].
- Extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Merge: only the selected lane is replaced with StoreData[7:0] or [15:0]. All other bits keep the value read in RD.
- Stores do not alter LoadData.
- MemRead and MemWrite are never both 1.

## Timing
- Request accepted at edge E0. Paths by op:
  - Loads: RD is the cycle after E0; Done is high in the next cycle (2 cycles after E0).
  - SW: WR is the cycle after E0; Done is high in the next cycle (2 cycles after E0).
  - SH/SB: RD, then WR, then Done (3 cycles after E0).
- Back-to-back: a Req in the DONE cycle is accepted at that edge, giving zero idle cycles between accesses.
- Memory write and read-address capture both happen at negedge inside the WR/RD cycle.
- MemReadData is valid before the closing posedge of RD.
- Reset values: state IDLE, and all outputs 0 (Busy, Done, Fault, MemWrite, MemRead, LoadData, MemAddress, MemWriteData).
- Reset mid-operation:
  - Takes effect at the next posedge.
  - A pending WR is never issued, so memory is unchanged.
  - No Done pulse is produced.
- Req is ignored while Busy=1.

## Configuration
- Macro `MAU_MISALIGN_CHECK_EN`, when defined:
  - LW/SW with Addr[1:0]≠0, or LH/LHU/SH with Addr[0]=1, is rejected at acceptance.
  - The FSM goes directly to DONE with Done=1 and Fault=1, 1 cycle after E0.
  - No MemRead or MemWrite is issued, and LoadData is unchanged.
- When undefined:
  - Fault is tied to 0.
  - Word accesses ignore Addr[1:0]; halfword accesses ignore Addr[0].
  - The access proceeds normally.

## Test plan
- Memory word 3 = 0x8899AABB:
  - LB at Addr 0x0E gives LoadData 0xFFFFFF99, with Done 2 cycles after acceptance.
  - LBU at Addr 0x0E gives 0x00000099.
- Same word:
  - LH at Addr 0x0E gives 0xFFFF8899.
  - LHU at Addr 0x0E gives 0x00008899.
  - LH at Addr 0x0C gives 0xFFFFAABB.
- SB at Addr 0x0D, StoreData 0x000000CC:
  - Expect MemRead for one cycle, then MemWrite for one cycle with MemWriteData 0x8899CCBB.
  - Done 3 cycles after acceptance; word 3 reads back 0x8899CCBB.
- SW at Addr 0x10 with 0xDEADBEEF, then LW at Addr 0x10 issued in the DONE cycle:
  - LoadData = 0xDEADBEEF.
  - Zero gap cycles between the two accesses.
- SH at Addr 0x0C with Reset asserted during RD:
  - Next cycle, all outputs are 0 and MemWrite never rises.
  - Word 3 is unchanged.
- LW at Addr 0x12:
  - With the macro defined: Done=Fault=1 one cycle after acceptance, with no memory strobe.
  - Without the macro: returns word 4.
